// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI burst RAM: command encodings, tx slot
// state type and a width helper used by the interface and top level.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } tx_state_e;

    // Payload width is the wider of address and data words.
    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_burst_ram_if.sv
// Command/response bus between the SPI slave (master modport) and the RAM
// (slave modport).
//   din        : {cmd[1:0], payload[PAY_W-1:0]}, qualified by rx_valid
//   dout       : read data, qualified by tx_valid, accepted with tx_ready
//   err        : one-cycle pulse on an out-of-range data access
//   rd_overrun : one-cycle pulse when a read is rejected (tx slot busy)
interface spi_burst_ram_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    import spi_ram_pkg::*;

    localparam int unsigned PAY_W = max_w(ADDR_W, DATA_W);

    logic [PAY_W+1:0]  din;
    logic              rx_valid;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              tx_ready;
    logic              err;
    logic              rd_overrun;

    modport master (
        output din, rx_valid, tx_ready,
        input  dout, tx_valid, err, rd_overrun
    );

    modport slave (
        input  din, rx_valid, tx_ready,
        output dout, tx_valid, err, rd_overrun
    );

endinterface

// File: rtl/spi_ram_ptr.sv
// Loadable pointer that increments and wraps at MEM_DEPTH-1.
//   clk, rst_n     : clock, synchronous active-low reset (ptr -> 0)
//   load, load_val : load a new pointer value (any value, even out of range)
//   inc            : advance by one, wrapping MEM_DEPTH-1 -> 0
//   ptr            : current pointer (registered)
//   out_of_range_c : ptr >= MEM_DEPTH (combinational)
module spi_ram_ptr #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr,
    output logic              out_of_range_c
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);

    // Out-of-range pointers step by +1 and roll over naturally at 2**ADDR_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + ADDR_W'(1);
        end
    end

    assign out_of_range_c = 32'(ptr) >= MEM_DEPTH;

endmodule

// File: rtl/spi_burst_ram.sv
// Command-decoded RAM behind the SPI slave with independent write/read
// pointers, optional burst auto-increment and a stallable tx slot.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : spi_burst_ram_if.slave (din/rx_valid in, dout/tx_valid out,
//                tx_ready in, err and rd_overrun status pulses out)
module spi_burst_ram
    import spi_ram_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256,
    parameter bit          AUTO_INC  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_burst_ram_if.slave  bus
);

    localparam int unsigned PAY_W = max_w(ADDR_W, DATA_W);

    logic [1:0]        cmd;
    logic [PAY_W-1:0]  payload;
    logic              wr_load_c, wr_access_c, rd_load_c, rd_req_c;
    logic              slot_free_c, rd_accept_c;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              wr_oor_c, rd_oor_c;
    logic [DATA_W-1:0] rd_word_c;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              err_q, err_d;
    logic              ovr_q, ovr_d;

    // Command decode; everything is qualified by rx_valid.
    assign cmd         = bus.din[PAY_W+1:PAY_W];
    assign payload     = bus.din[PAY_W-1:0];
    assign wr_load_c   = bus.rx_valid && (cmd == CMD_WR_ADDR);
    assign wr_access_c = bus.rx_valid && (cmd == CMD_WR_DATA);
    assign rd_load_c   = bus.rx_valid && (cmd == CMD_RD_ADDR);
    assign rd_req_c    = bus.rx_valid && (cmd == CMD_RD_DATA);

    // The slot is free when empty or being drained this very cycle.
    assign slot_free_c = (state_q == IDLE) || bus.tx_ready;
    assign rd_accept_c = rd_req_c && slot_free_c;

    spi_ram_ptr #(
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_wr_ptr (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (wr_load_c),
        .load_val       (payload[ADDR_W-1:0]),
        .inc            (wr_access_c && AUTO_INC),
        .ptr            (wr_ptr),
        .out_of_range_c (wr_oor_c)
    );

    spi_ram_ptr #(
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_rd_ptr (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (rd_load_c),
        .load_val       (payload[ADDR_W-1:0]),
        .inc            (rd_accept_c && AUTO_INC),
        .ptr            (rd_ptr),
        .out_of_range_c (rd_oor_c)
    );

    // Storage is never reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (wr_access_c && !wr_oor_c) begin
            mem[wr_ptr] <= payload[DATA_W-1:0];
        end
    end

    // Out-of-range reads return zero.
    always_comb begin
        rd_word_c = '0;
        if (!rd_oor_c) begin
            rd_word_c = mem[rd_ptr];
        end
    end

    // Tx slot state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dout_q  <= '0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next state: load on accepted read, drain on tx_ready otherwise.
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        err_d   = (wr_access_c && wr_oor_c) || (rd_accept_c && rd_oor_c);
        ovr_d   = rd_req_c && !slot_free_c;
        case (state_q)
            IDLE: begin
                if (rd_accept_c) begin
                    state_d = FULL;
                    dout_d  = rd_word_c;
                end
            end
            FULL: begin
                if (rd_accept_c) begin
                    dout_d = rd_word_c;
                end else if (bus.tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dout       = dout_q;
    assign bus.tx_valid   = (state_q == FULL);
    assign bus.err        = err_q;
    assign bus.rd_overrun = ovr_q;

endmodule

// File: tb/tb_spi_burst_ram.sv
// Directed bench for spi_burst_ram. Three instances share one stimulus
// stream: dut_a (defaults), dut_b (MEM_DEPTH=200), dut_c (AUTO_INC=0).
module tb_spi_burst_ram;

    logic       clk;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic       tx_ready;

    int n_vec  = 0;
    int n_miss = 0;

    spi_burst_ram_if #(.DATA_W(8), .ADDR_W(8)) if_a ();
    spi_burst_ram_if #(.DATA_W(8), .ADDR_W(8)) if_b ();
    spi_burst_ram_if #(.DATA_W(8), .ADDR_W(8)) if_c ();

    assign if_a.din = din;  assign if_a.rx_valid = rx_valid;  assign if_a.tx_ready = tx_ready;
    assign if_b.din = din;  assign if_b.rx_valid = rx_valid;  assign if_b.tx_ready = tx_ready;
    assign if_c.din = din;  assign if_c.rx_valid = rx_valid;  assign if_c.tx_ready = tx_ready;

    spi_burst_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1'b1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    spi_burst_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1'b1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    spi_burst_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1'b0))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] p, input logic rdy);
        din      = {c, p};
        rx_valid = 1'b1;
        tx_ready = rdy;
        cyc();
        rx_valid = 1'b0;
        din      = '0;
    endtask

    task automatic idle(input logic rdy);
        rx_valid = 1'b0;
        tx_ready = rdy;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) cyc();
        n_vec++; if ({if_a.dout, if_a.tx_valid, if_a.err, if_a.rd_overrun} !== 11'h0) begin
            n_miss++; $display("FAIL reset_a: got %h expected 000", {if_a.dout, if_a.tx_valid, if_a.err, if_a.rd_overrun});
        end
        n_vec++; if ({if_b.dout, if_b.tx_valid, if_b.err, if_b.rd_overrun} !== 11'h0) begin
            n_miss++; $display("FAIL reset_b: got %h expected 000", {if_b.dout, if_b.tx_valid, if_b.err, if_b.rd_overrun});
        end
        n_vec++; if ({if_c.dout, if_c.tx_valid, if_c.err, if_c.rd_overrun} !== 11'h0) begin
            n_miss++; $display("FAIL reset_c: got %h expected 000", {if_c.dout, if_c.tx_valid, if_c.err, if_c.rd_overrun});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        send(2'b00, 8'h10, 1'b1);
        send(2'b01, 8'hA5, 1'b1);
        send(2'b10, 8'h10, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        n_vec++; if (if_a.tx_valid !== 1'b1) begin
            n_miss++; $display("FAIL basic_tx_valid: got %b expected 1", if_a.tx_valid);
        end
        n_vec++; if (if_a.dout !== 8'hA5) begin
            n_miss++; $display("FAIL basic_dout: got %h expected a5", if_a.dout);
        end
        n_vec++; if (if_a.err !== 1'b0) begin
            n_miss++; $display("FAIL basic_err: got %b expected 0", if_a.err);
        end
        idle(1'b1);
        n_vec++; if (if_a.tx_valid !== 1'b0) begin
            n_miss++; $display("FAIL basic_drain: got %b expected 0", if_a.tx_valid);
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        send(2'b00, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) send(2'b01, exp_d[i], 1'b1);
        send(2'b10, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send(2'b11, 8'h00, 1'b1);
            n_vec++; if (if_a.tx_valid !== 1'b1 || if_a.dout !== exp_d[i]) begin
                n_miss++; $display("FAIL burst_%0d: got v=%b d=%h expected v=1 d=%h", i, if_a.tx_valid, if_a.dout, exp_d[i]);
            end
        end
        idle(1'b1);
        n_vec++; if (if_a.tx_valid !== 1'b0) begin
            n_miss++; $display("FAIL burst_drain: got %b expected 0", if_a.tx_valid);
        end
    endtask

    task automatic test_overrun();
        send(2'b00, 8'h40, 1'b1);
        send(2'b01, 8'h5A, 1'b1);
        send(2'b01, 8'h6B, 1'b1);
        send(2'b01, 8'h7C, 1'b1);
        send(2'b10, 8'h40, 1'b1);
        send(2'b11, 8'h00, 1'b0);
        n_vec++; if (if_a.tx_valid !== 1'b1 || if_a.dout !== 8'h5A || if_a.rd_overrun !== 1'b0) begin
            n_miss++; $display("FAIL ovr_first: got v=%b d=%h o=%b expected v=1 d=5a o=0", if_a.tx_valid, if_a.dout, if_a.rd_overrun);
        end
        send(2'b11, 8'h00, 1'b0);
        n_vec++; if (if_a.rd_overrun !== 1'b1 || if_a.dout !== 8'h5A || if_a.tx_valid !== 1'b1) begin
            n_miss++; $display("FAIL ovr_pulse: got o=%b d=%h v=%b expected o=1 d=5a v=1", if_a.rd_overrun, if_a.dout, if_a.tx_valid);
        end
        idle(1'b0);
        n_vec++; if (if_a.rd_overrun !== 1'b0 || if_a.dout !== 8'h5A || if_a.tx_valid !== 1'b1) begin
            n_miss++; $display("FAIL ovr_hold: got o=%b d=%h v=%b expected o=0 d=5a v=1", if_a.rd_overrun, if_a.dout, if_a.tx_valid);
        end
        idle(1'b1);
        n_vec++; if (if_a.tx_valid !== 1'b0) begin
            n_miss++; $display("FAIL ovr_drain: got %b expected 0", if_a.tx_valid);
        end
        send(2'b11, 8'h00, 1'b1);
        n_vec++; if (if_a.dout !== 8'h6B) begin
            n_miss++; $display("FAIL ovr_rd_ptr: got %h expected 6b", if_a.dout);
        end
        idle(1'b1);
    endtask

    task automatic test_range();
        send(2'b00, 8'd199, 1'b1);
        send(2'b01, 8'h77, 1'b1);
        n_vec++; if (if_b.err !== 1'b0) begin
            n_miss++; $display("FAIL range_wr199_err: got %b expected 0", if_b.err);
        end
        send(2'b01, 8'h77, 1'b1);
        n_vec++; if (if_b.err !== 1'b0) begin
            n_miss++; $display("FAIL range_wr0_err: got %b expected 0", if_b.err);
        end
        send(2'b10, 8'd199, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        n_vec++; if (if_b.dout !== 8'h77 || if_b.err !== 1'b0) begin
            n_miss++; $display("FAIL range_rd199: got d=%h e=%b expected d=77 e=0", if_b.dout, if_b.err);
        end
        send(2'b11, 8'h00, 1'b1);
        n_vec++; if (if_b.dout !== 8'h77 || if_b.err !== 1'b0) begin
            n_miss++; $display("FAIL range_rd_wrap0: got d=%h e=%b expected d=77 e=0", if_b.dout, if_b.err);
        end
        send(2'b10, 8'd250, 1'b1);
        n_vec++; if (if_b.err !== 1'b0) begin
            n_miss++; $display("FAIL range_load_oor: got %b expected 0", if_b.err);
        end
        send(2'b11, 8'h00, 1'b1);
        n_vec++; if (if_b.err !== 1'b1 || if_b.dout !== 8'h00 || if_b.tx_valid !== 1'b1) begin
            n_miss++; $display("FAIL range_rd_oor: got e=%b d=%h v=%b expected e=1 d=00 v=1", if_b.err, if_b.dout, if_b.tx_valid);
        end
        idle(1'b1);
        n_vec++; if (if_b.err !== 1'b0 || if_b.tx_valid !== 1'b0) begin
            n_miss++; $display("FAIL range_err_pulse: got e=%b v=%b expected e=0 v=0", if_b.err, if_b.tx_valid);
        end
        send(2'b00, 8'd210, 1'b1);
        send(2'b01, 8'h55, 1'b1);
        n_vec++; if (if_b.err !== 1'b1) begin
            n_miss++; $display("FAIL range_wr_oor: got %b expected 1", if_b.err);
        end
        idle(1'b1);
    endtask

    task automatic test_reset_mid();
        send(2'b00, 8'h50, 1'b1);
        send(2'b01, 8'h3C, 1'b1);
        send(2'b10, 8'h50, 1'b1);
        send(2'b11, 8'h00, 1'b0);
        n_vec++; if (if_a.tx_valid !== 1'b1 || if_a.dout !== 8'h3C) begin
            n_miss++; $display("FAIL rstmid_pre: got v=%b d=%h expected v=1 d=3c", if_a.tx_valid, if_a.dout);
        end
        rst_n = 1'b0;
        idle(1'b0);
        n_vec++; if (if_a.tx_valid !== 1'b0 || if_a.dout !== 8'h00) begin
            n_miss++; $display("FAIL rstmid_clear: got v=%b d=%h expected v=0 d=00", if_a.tx_valid, if_a.dout);
        end
        rst_n = 1'b1;
        send(2'b11, 8'h00, 1'b1);
        n_vec++; if (if_a.tx_valid !== 1'b1 || if_a.dout !== 8'h11) begin
            n_miss++; $display("FAIL rstmid_rd0: got v=%b d=%h expected v=1 d=11", if_a.tx_valid, if_a.dout);
        end
        send(2'b01, 8'h99, 1'b1);
        send(2'b10, 8'h50, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        n_vec++; if (if_a.dout !== 8'h3C) begin
            n_miss++; $display("FAIL rstmid_retain: got %h expected 3c", if_a.dout);
        end
        send(2'b10, 8'h00, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        n_vec++; if (if_a.dout !== 8'h99) begin
            n_miss++; $display("FAIL rstmid_wr_ptr: got %h expected 99", if_a.dout);
        end
        idle(1'b1);
    endtask

    task automatic test_static_ptr();
        send(2'b00, 8'h06, 1'b1);
        send(2'b01, 8'hE6, 1'b1);
        send(2'b00, 8'h05, 1'b1);
        send(2'b01, 8'h01, 1'b1);
        send(2'b01, 8'h02, 1'b1);
        send(2'b10, 8'h05, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        n_vec++; if (if_c.dout !== 8'h02 || if_c.err !== 1'b0) begin
            n_miss++; $display("FAIL static_rd5: got d=%h e=%b expected d=02 e=0", if_c.dout, if_c.err);
        end
        send(2'b11, 8'h00, 1'b1);
        n_vec++; if (if_c.dout !== 8'h02 || if_c.tx_valid !== 1'b1) begin
            n_miss++; $display("FAIL static_rd5_again: got d=%h v=%b expected d=02 v=1", if_c.dout, if_c.tx_valid);
        end
        send(2'b10, 8'h06, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        n_vec++; if (if_c.dout !== 8'hE6) begin
            n_miss++; $display("FAIL static_rd6: got %h expected e6", if_c.dout);
        end
        idle(1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        din      = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        test_reset();
        test_basic();
        test_burst();
        test_overrun();
        test_range();
        test_reset_mid();
        test_static_ptr();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
